mem_responder: RTL

Memory-side responder for the core's load/store request interface. Accepts one request at a time (direction `mem_dir_e`, size `mem_size_e`, byte address, write data) and services it against an internal word-organised RAM after a configurable wait. Returns read data sign- or zero-extended per size, or an error for misaligned, out-of-range or illegal requests. It sits between the core's memory port and the system bus as the data scratchpad and as the reference target for core bring-up.

---
 rtl/core_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 28 ++
 rtl/mem_responder.sv | 93 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared memory-interface types and request legality check
package core_pkg;
    typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_dir_e;
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;
    typedef enum logic [1:0] {MRS_IDLE, MRS_WAIT, MRS_RESP} mem_rsp_state_e;

    function automatic logic mem_size_legal(mem_dir_e dir, mem_size_e size, logic [1:0] addr_lo);
        return size == MEM_B
            || (size == MEM_BU && dir == MEM_READ)
            || (size == MEM_H && !addr_lo[0])
            || (size == MEM_HU && dir == MEM_READ && !addr_lo[0])
            || (size == MEM_W && addr_lo == 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane shift/byte enables and load lane extract/extension
module mem_lane_align
    import core_pkg::*;
(
    input  logic [31:0] wdata,
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    output logic [31:0] wdata_lane,
    output logic [3:0]  be,
    output logic [31:0] rdata
);
    logic        half;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    always_comb begin
        half       = size == MEM_H || size == MEM_HU;
        wdata_lane = size == MEM_W ? wdata : half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        be         = size == MEM_W ? 4'hf : half ? (addr_lo[1] ? 4'hc : 4'h3) : 4'b0001 << addr_lo;
        rd_byte    = 8'(rword >> {addr_lo, 3'b000});
        rd_half    = addr_lo[1] ? rword[31:16] : rword[15:0];
        rdata      = size == MEM_W  ? rword :
                     size == MEM_B  ? {{24{rd_byte[7]}}, rd_byte} :
                     size == MEM_BU ? {24'h0, rd_byte} :
                     size == MEM_H  ? {{16{rd_half[15]}}, rd_half} :
                     size == MEM_HU ? {16'h0, rd_half} : 32'h0;
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM responder with configurable response latency
module mem_responder
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_dir_e    req_dir,
    input  mem_size_e   req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    mem_rsp_state_e state, state_n;
    logic [3:0]     cnt;
    mem_dir_e       l_dir, e_dir;
    mem_size_e      l_size, e_size;
    logic [31:0]    l_addr, l_wdata, e_addr, e_wdata, e_wsh, e_rdata;
    logic [3:0]     e_be;
    logic           req_hs, exec, err;
    logic [31:0]    mem [DEPTH_WORDS];

    assign req_ready = state == MRS_IDLE && !rst;
    assign rsp_valid = state == MRS_RESP;
    assign req_hs    = req_valid && req_ready;
    // zero latency executes on the handshake edge itself, before the latch holds the request
    assign e_dir   = state == MRS_IDLE ? req_dir : l_dir;
    assign e_size  = state == MRS_IDLE ? req_size : l_size;
    assign e_addr  = state == MRS_IDLE ? req_addr : l_addr;
    assign e_wdata = state == MRS_IDLE ? req_wdata : l_wdata;
    assign err     = !mem_size_legal(e_dir, e_size, e_addr[1:0]) || e_addr >= 32'(DEPTH_WORDS * 4);
    assign exec    = !rst && (state == MRS_IDLE ? req_hs && LATENCY == 0 : state == MRS_WAIT && cnt == 4'd0);

    mem_lane_align u_align (
        .wdata     (e_wdata),
        .size      (e_size),
        .addr_lo   (e_addr[1:0]),
        .rword     (mem[e_addr[AW+1:2]]),
        .wdata_lane(e_wsh),
        .be        (e_be),
        .rdata     (e_rdata)
    );

    always_comb begin
        state_n = state == MRS_IDLE ? (req_hs ? (LATENCY == 0 ? MRS_RESP : MRS_WAIT) : MRS_IDLE) :
                  state == MRS_WAIT ? (cnt == 4'd0 ? MRS_RESP : MRS_WAIT) :
                  (rsp_ready ? MRS_IDLE : MRS_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MRS_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (req_hs)
                cnt <= LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
            else if (state == MRS_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (exec) begin
                rsp_rdata <= err || e_dir == MEM_WRITE ? 32'h0 : e_rdata;
                rsp_err   <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) begin
            l_dir   <= req_dir;
            l_size  <= req_size;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (exec && !err && e_dir == MEM_WRITE)
            for (int i = 0; i < 4; i++)
                if (e_be[i])
                    mem[e_addr[AW+1:2]][8*i +: 8] <= e_wsh[8*i +: 8];
    end
endmodule
